fpu_xfer_seq: RTL and testbench

Block-transfer sequencer for the FPU register file; implements VLDM/VSTM-style multi-register moves between data memory and FP registers. It drives the register-file read/write ports (`ra1`/`A1`/`rd1`, `we3`/`wa3`/`A3`/`wd3`, `single`) and handles a req/ack memory port. It sits beside the multicycle control unit, which launches it with `start` and stalls until `done`.

---
 rtl/fpu_xfer_pkg.sv | 25 ++
 rtl/fpu_xfer_elem_ctr.sv | 44 ++++
 rtl/fpu_xfer_seq.sv | 162 ++++++++++++++++
 tb/tb_fpu_xfer_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_xfer_pkg.sv
// Shared types and constants for the FPU block-transfer sequencer (VLDM/VSTM).
// Optional feature macro used by the top: FPU_XFER_WBADDR_EN.
package fpu_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDRF = 3'd1,
        MEM  = 3'd2,
        WBRF = 3'd3,
        FIN  = 3'd4
    } xfer_state_t;

    localparam int XFER_STRIDE = 4;
    localparam int EL_W        = 5;

    // Single elements name a whole register; half elements pack {reg, half-select}.
    function automatic logic [3:0] el_reg(input logic [EL_W-1:0] el, input logic single);
        return single ? el[3:0] : el[4:1];
    endfunction

    function automatic logic el_half(input logic [EL_W-1:0] el, input logic single);
        return single ? 1'b0 : el[0];
    endfunction

endpackage

// File: rtl/fpu_xfer_elem_ctr.sv
// Element/address/count tracker for one block transfer; loaded at launch, stepped per element.
module fpu_xfer_elem_ctr
    import fpu_xfer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_init,
    input  logic              advance,
    input  logic              single,
    input  logic [EL_W-1:0]   first_el,
    input  logic [EL_W-1:0]   count,
    input  logic [ADDR_W-1:0] base,
    output logic [EL_W-1:0]   el,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [EL_W-1:0] remaining;
    logic            single_q;

    // Single mode keeps the index in the low nibble so it wraps 15 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            el        <= '0;
            addr      <= '0;
            remaining <= '0;
            single_q  <= 1'b0;
        end else if (load_init) begin
            el        <= single ? {1'b0, first_el[3:0]} : first_el;
            addr      <= base;
            remaining <= count;
            single_q  <= single;
        end else if (advance) begin
            el        <= single_q ? {1'b0, el[3:0] + 4'd1} : el + EL_W'(1);
            addr      <= addr + ADDR_W'(XFER_STRIDE);
            remaining <= remaining - EL_W'(1);
        end
    end

    assign last = (remaining == EL_W'(1));

endmodule

// File: rtl/fpu_xfer_seq.sv
// VLDM/VSTM block-transfer sequencer between data memory and the FPU register file.
// Define FPU_XFER_WBADDR_EN to add the base-register writeback address outputs.
module fpu_xfer_seq
    import fpu_xfer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load,
    input  logic              single,
    input  logic [4:0]        first_el,
    input  logic [4:0]        count,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rf_ra1,
    output logic              rf_A1,
    input  logic [31:0]       rf_rd1,
    output logic              rf_we3,
    output logic [3:0]        rf_wa3,
    output logic              rf_A3,
    output logic [31:0]       rf_wd3,
    output logic              rf_single,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
`ifdef FPU_XFER_WBADDR_EN
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_addr_vld,
`endif
    input  logic              mem_ack
);

    xfer_state_t       state;
    xfer_state_t       next_state;
    logic              load_q;
    logic              single_q;
    logic [31:0]       data_q;
    logic              load_init;
    logic              advance;
    logic [EL_W-1:0]   el;
    logic [ADDR_W-1:0] addr;
    logic              last;

    fpu_xfer_elem_ctr #(
        .ADDR_W(ADDR_W)
    ) u_elem_ctr (
        .clk      (clk),
        .reset    (reset),
        .load_init(load_init),
        .advance  (advance),
        .single   (single),
        .first_el (first_el),
        .count    (count),
        .base     (base),
        .el       (el),
        .addr     (addr),
        .last     (last)
    );

    // data_q is shared: store data read from the RF, or load data returned by memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            load_q   <= 1'b0;
            single_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                load_q   <= load;
                single_q <= single;
            end
            if (state == RDRF) begin
                data_q <= single_q ? rf_rd1 : {16'b0, rf_rd1[15:0]};
            end
            if (state == MEM && mem_ack && load_q) begin
                data_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        load_init  = 1'b0;
        advance    = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        rf_ra1     = '0;
        rf_A1      = 1'b0;
        rf_we3     = 1'b0;
        rf_wa3     = '0;
        rf_A3      = 1'b0;
        rf_wd3     = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    load_init = 1'b1;
                    if (count == '0) begin
                        next_state = FIN;
                    end else if (load) begin
                        next_state = MEM;
                    end else begin
                        next_state = RDRF;
                    end
                end
            end
            RDRF: begin
                rf_ra1     = el_reg(el, single_q);
                rf_A1      = el_half(el, single_q);
                next_state = MEM;
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = !load_q;
                mem_addr  = addr;
                mem_wdata = data_q;
                if (mem_ack) begin
                    if (load_q) begin
                        next_state = WBRF;
                    end else begin
                        advance    = 1'b1;
                        next_state = last ? FIN : RDRF;
                    end
                end
            end
            WBRF: begin
                rf_we3     = 1'b1;
                rf_wa3     = el_reg(el, single_q);
                rf_A3      = el_half(el, single_q);
                rf_wd3     = single_q ? data_q : {16'b0, data_q[15:0]};
                advance    = 1'b1;
                next_state = last ? FIN : MEM;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign rf_single = single_q;

`ifdef FPU_XFER_WBADDR_EN
    // After the final advance the running address already equals base + 4*count.
    assign wb_addr     = (state == FIN) ? addr : '0;
    assign wb_addr_vld = (state == FIN);
`endif

endmodule

// File: tb/tb_fpu_xfer_seq.sv
// Self-checking bench for fpu_xfer_seq: RF and memory models plus a transaction-order reference.
// Build with FPU_XFER_WBADDR_EN defined to also exercise the writeback address outputs.
module tb_fpu_xfer_seq;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              load;
    logic              single;
    logic [4:0]        first_el;
    logic [4:0]        count;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              done;
    logic [3:0]        rf_ra1;
    logic              rf_A1;
    logic [31:0]       rf_rd1;
    logic              rf_we3;
    logic [3:0]        rf_wa3;
    logic              rf_A3;
    logic [31:0]       rf_wd3;
    logic              rf_single;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
`ifdef FPU_XFER_WBADDR_EN
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_addr_vld;
`endif

    always #5 clk = ~clk;

    fpu_xfer_seq #(
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load       (load),
        .single     (single),
        .first_el   (first_el),
        .count      (count),
        .base       (base),
        .busy       (busy),
        .done       (done),
        .rf_ra1     (rf_ra1),
        .rf_A1      (rf_A1),
        .rf_rd1     (rf_rd1),
        .rf_we3     (rf_we3),
        .rf_wa3     (rf_wa3),
        .rf_A3      (rf_A3),
        .rf_wd3     (rf_wd3),
        .rf_single  (rf_single),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
`ifdef FPU_XFER_WBADDR_EN
        .wb_addr    (wb_addr),
        .wb_addr_vld(wb_addr_vld),
`endif
        .mem_ack    (mem_ack)
    );

    logic [31:0] rf_model [16] = '{
        32'h1000_A001, 32'h1101_A102, 32'h1202_A203, 32'h1303_A304,
        32'h1404_A405, 32'h1505_A506, 32'h1606_A607, 32'h1707_A708,
        32'h1808_A809, 32'h1909_A90A, 32'h1A0A_AA0B, 32'h1B0B_AB0C,
        32'h1C0C_AC0D, 32'h1D0D_AD0E, 32'h1E0E_AE0F, 32'h1F0F_AF10
    };
    logic [31:0] mem_img [logic [31:0]];

    // Register file returns the selected half in the low 16 bits in half mode.
    assign rf_rd1 = rf_single ? rf_model[rf_ra1]
                  : {16'h0, (rf_A1 ? rf_model[rf_ra1][31:16] : rf_model[rf_ra1][15:0])};

    logic [4:0]  m_el   [32];
    logic [31:0] m_addr [32];
    logic [31:0] m_data [32];
    int          n_tr;
    logic        cfg_load;
    logic        cfg_single;
    int          ack_delay;
    bit          checking = 1'b0;

    int tot_mem = 0, tot_rf = 0, tot_req = 0, tot_we = 0, wait_cnt = 0;
    int base_mem, base_rf, base_req, base_we;
    int n_cmp = 0, n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1357};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare process, memory responder and register-file write model in one place.
    always @(negedge clk) begin
        int k;
        int r;
        if (checking) begin
            if (mem_req) begin
                tot_req++;
                k = tot_mem - base_mem;
                if (k >= n_tr) begin
                    check_output("unexpected_mem_req", 32'(mem_req), 32'd0);
                    mem_ack = 1'b0;
                end else begin
                    check_output("mem_addr", mem_addr, m_addr[k]);
                    check_output("mem_we", 32'(mem_we), 32'(!cfg_load));
                    if (!cfg_load) check_output("mem_wdata", mem_wdata, m_data[k]);
                    if (wait_cnt == ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_word(m_addr[k]);
                        wait_cnt  = 0;
                        tot_mem++;
                    end else begin
                        mem_ack = 1'b0;
                        wait_cnt++;
                    end
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (rf_we3) begin
                tot_we++;
                k = tot_rf - base_rf;
                if (!cfg_load || k >= n_tr) begin
                    check_output("unexpected_rf_we3", 32'(rf_we3), 32'd0);
                end else begin
                    r = cfg_single ? int'(m_el[k]) : int'(m_el[k]) / 2;
                    check_output("rf_wa3", 32'(rf_wa3), 32'(r));
                    check_output("rf_A3", 32'(rf_A3), cfg_single ? 32'd0 : 32'(m_el[k] % 2));
                    if (cfg_single) check_output("rf_wd3", rf_wd3, m_data[k]);
                    else check_output("rf_wd3_half", {16'h0, rf_wd3[15:0]}, {16'h0, m_data[k][15:0]});
                    tot_rf++;
                end
                if (rf_single) rf_model[rf_wa3] = rf_wd3;
                else if (rf_A3) rf_model[rf_wa3][31:16] = rf_wd3[15:0];
                else rf_model[rf_wa3][15:0] = rf_wd3[15:0];
            end
            if (busy) check_output("rf_single", 32'(rf_single), 32'(cfg_single));
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic build_model(input logic ld, input logic sg, input logic [4:0] fe,
                               input logic [4:0] cnt, input logic [31:0] bs, input int dly);
        int e;
        for (int i = 0; i < int'(cnt); i++) begin
            e         = sg ? (int'(fe) % 16 + i) % 16 : (int'(fe) + i) % 32;
            m_el[i]   = 5'(e);
            m_addr[i] = bs + 32'(4 * i);
            if (ld) m_data[i] = mem_word(m_addr[i]);
            else if (sg) m_data[i] = rf_model[e];
            else m_data[i] = {16'h0, (e % 2 == 1) ? rf_model[e / 2][31:16] : rf_model[e / 2][15:0]};
        end
        cfg_load   = ld;
        cfg_single = sg;
        n_tr       = int'(cnt);
        ack_delay  = dly;
        base_mem   = tot_mem;
        base_rf    = tot_rf;
        base_req   = tot_req;
        base_we    = tot_we;
        checking   = 1'b1;
    endtask

    task automatic apply_stimulus(input logic ld, input logic sg, input logic [4:0] fe,
                                  input logic [4:0] cnt, input logic [31:0] bs);
        @(negedge clk);
        start    = 1'b1;
        load     = ld;
        single   = sg;
        first_el = fe;
        count    = cnt;
        base     = bs;
    endtask

    task automatic run_xfer(input logic ld, input logic sg, input logic [4:0] fe,
                            input logic [4:0] cnt, input logic [31:0] bs, input int dly,
                            output int done_cyc);
        build_model(ld, sg, fe, cnt, bs, dly);
        apply_stimulus(ld, sg, fe, cnt, bs);
        done_cyc = -1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check_output("busy_during", 32'(busy), 32'd1);
            if (done) begin
                done_cyc = c;
`ifdef FPU_XFER_WBADDR_EN
                check_output("wb_addr", wb_addr, bs + 32'(4 * int'(cnt)));
                check_output("wb_addr_vld", 32'(wb_addr_vld), 32'd1);
`endif
                break;
            end
        end
        if (done_cyc < 0) check_output("done_timeout", 32'(done), 32'd1);
        else check_output("done_cycle", 32'(done_cyc), 32'(int'(cnt) * (dly + 2) + 1));
        check_output("mem_xfers", 32'(tot_mem - base_mem), 32'(cnt));
        check_output("rf_writes", 32'(tot_we - base_we), ld ? 32'(cnt) : 32'd0);
        check_output("req_cycles", 32'(tot_req - base_req), 32'(int'(cnt) * (dly + 1)));
        @(negedge clk);
        check_output("busy_after", 32'(busy), 32'd0);
        check_output("done_pulse", 32'(done), 32'd0);
        checking = 1'b0;
    endtask

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; load = 1'b0; single = 1'b0;
        first_el = '0; count = '0; base = '0;
        mem_img[32'h40] = 32'hABCD_1234;
        mem_img[32'h44] = 32'h5555_FFFF;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_rf_we3", 32'(rf_we3), 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_rf_single", 32'(rf_single), 32'd0);
        reset = 1'b0;

        $display("[TB] store single s14..s0 at 0x100");
        run_xfer(1'b0, 1'b1, 5'd14, 5'd3, 32'h100, 0, dc);
        check_output("t1_done_at_7", 32'(dc), 32'd7);
        check_output("t1_el0", 32'(m_el[0]), 32'd14);
        check_output("t1_el2_wrap", 32'(m_el[2]), 32'd0);
        check_output("t1_addr2", m_addr[2], 32'h108);

        $display("[TB] load half {3,1} x2 from 0x40");
        run_xfer(1'b1, 1'b0, 5'd7, 5'd2, 32'h40, 0, dc);
        check_output("t2_rf3_hi", {16'h0, rf_model[3][31:16]}, 32'h0000_1234);
        check_output("t2_rf3_lo_kept", {16'h0, rf_model[3][15:0]}, 32'h0000_A304);
        check_output("t2_rf4_lo", {16'h0, rf_model[4][15:0]}, 32'h0000_FFFF);
        check_output("t2_rf4_hi_kept", {16'h0, rf_model[4][31:16]}, 32'h0000_1404);

        $display("[TB] load single with 3-cycle ack delay");
        run_xfer(1'b1, 1'b1, 5'd15, 5'd2, 32'h380, 3, dc);

        $display("[TB] zero-count transfer");
        run_xfer(1'b0, 1'b1, 5'd3, 5'd0, 32'h500, 0, dc);
        check_output("t4_done_next", 32'(dc), 32'd1);

        $display("[TB] store half wrapping past {15,1}");
        run_xfer(1'b0, 1'b0, 5'd31, 5'd3, 32'h10, 1, dc);

        $display("[TB] long transfers");
        run_xfer(1'b1, 1'b0, 5'd20, 5'd16, 32'h800, 0, dc);
        run_xfer(1'b0, 1'b1, 5'd5, 5'd16, 32'h900, 0, dc);

        $display("[TB] reset during second element memory phase");
        build_model(1'b1, 1'b1, 5'd2, 5'd3, 32'h600, 2);
        apply_stimulus(1'b1, 1'b1, 5'd2, 5'd3, 32'h600);
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (mem_req && (tot_rf - base_rf) == 1) begin
                dc = c;
                break;
            end
        end
        if (dc < 0) check_output("reset_setup_timeout", 32'(mem_req), 32'd1);
        checking = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_output("abort_mem_req", 32'(mem_req), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_rf_we3", 32'(rf_we3), 32'd0);
        reset = 1'b0;
        run_xfer(1'b1, 1'b1, 5'd2, 5'd3, 32'h600, 0, dc);

        $display("[TB] store single x4 at 0x200");
        run_xfer(1'b0, 1'b1, 5'd8, 5'd4, 32'h200, 0, dc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
